// File: rtl/signmag_scan_pkg.sv
// rtl/signmag_scan_pkg.sv - shared flag indices, blank pattern and hex-to-7-segment decode
package signmag_scan_pkg;

    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_NZ    = 0;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-high {g,f,e,d,c,b,a}; callers invert for the active-low bank.
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - digit-scan driver for the 7-segment bank; SIGNMAG_SCAN_ZERO_BLANK_EN enables leading-zero blanking
module seg7_scan
    import signmag_scan_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS*4-1:0]   disp_mag_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            segs_o
);

    localparam int PSW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PSW-1:0] PRE_LAST = PSW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

    logic [PSW-1:0]    pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        nib;
    logic [DIGITS-1:0] an_d, an_q;
    logic [6:0]        segs_d, segs_q;

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        nib = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IW'(d)) begin
                nib = disp_mag_i[d*4 +: 4];
            end
        end
        an_d   = ~(DIGITS'(1) << idx_q);
        segs_d = ~hex7seg(nib);
`ifdef SIGNMAG_SCAN_ZERO_BLANK_EN
        // Blank when this nibble and everything above it is zero; digit 0 always shows.
        if ((idx_q != '0) && ((disp_mag_i >> {idx_q, 2'b00}) == '0)) begin
            segs_d = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            idx_q  <= '0;
            an_q   <= ~DIGITS'(1);
            segs_q <= ~hex7seg(4'h0);
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            segs_q <= segs_d;
        end
    end

    assign an_o   = an_q;
    assign segs_o = segs_q;

endmodule

// File: rtl/signmag_addsub_scan.sv
// rtl/signmag_addsub_scan.sv - 2-stage sign-magnitude add/sub with flags and scanned hex display; SIGNMAG_SCAN_ZERO_BLANK_EN blanks leading zeros
module signmag_addsub_scan
    import signmag_scan_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_sub,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_sum,
    output logic [2:0]        out_c,
    output logic              neg,
    output logic [6:0]        SEGS,
    output logic [DIGITS-1:0] AN
);

    // Sign-magnitude to two's complement; -0 collapses to 0.
    function automatic logic [WIDTH-1:0] sm_to_tc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] mag;
        mag = v;
        mag[WIDTH-1] = 1'b0;
        return v[WIDTH-1] ? -mag : mag;
    endfunction

    logic [WIDTH-1:0] a_d, b_tc, b_d, a_q, b_q;
    logic             v1_q;

    assign a_d  = sm_to_tc(in_a);
    assign b_tc = sm_to_tc(in_b);
    assign b_d  = in_sub ? -b_tc : b_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end
    end

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum_d, disp_d, sum_q, disp_q;
    logic [2:0]       c_d, c_q;
    logic             ovf, neg_d, neg_q, out_valid_q;

    always_comb begin
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        sum_d   = sum_ext[WIDTH-1:0];
        ovf     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
        c_d             = '0;
        c_d[FLAG_CARRY] = sum_ext[WIDTH];
        c_d[FLAG_OVF]   = ovf;
        c_d[FLAG_NZ]    = |sum_d;
        // An overflowed sum shows its raw bits and never lights the negative indicator.
        disp_d = sum_d;
        neg_d  = 1'b0;
        if (sum_d[WIDTH-1] && !ovf) begin
            disp_d = -sum_d;
            neg_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_q         <= '0;
            disp_q      <= '0;
            neg_q       <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                sum_q  <= sum_d;
                c_q    <= c_d;
                disp_q <= disp_d;
                neg_q  <= neg_d;
            end
        end
    end

    logic [DIGITS*4-1:0] disp_pad;

    always_comb begin
        disp_pad = '0;
        disp_pad[WIDTH-1:0] = disp_q;
    end

    seg7_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_mag_i (disp_pad),
        .an_o       (AN),
        .segs_o     (SEGS)
    );

    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_c     = c_q;
    assign neg       = ~neg_q;

endmodule

// File: tb/tb_signmag_addsub_scan.sv
// tb/tb_signmag_addsub_scan.sv - scoreboard bench for signmag_addsub_scan (WIDTH=8, DIGITS=2, SCAN_DIV=4)
module tb_signmag_addsub_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sub = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       out_valid;
    logic [7:0] out_sum;
    logic [2:0] out_c;
    logic       neg;
    logic [6:0] SEGS;
    logic [1:0] AN;

    signmag_addsub_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .out_valid(out_valid), .out_sum(out_sum), .out_c(out_c),
        .neg(neg), .SEGS(SEGS), .AN(AN)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sum;
        logic [2:0] c;
        logic       neg;
        logic [7:0] disp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [6:0] hex_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [7:0] tv_a    [5] = '{8'h05, 8'h03, 8'h7F, 8'hFF, 8'h80};
    logic [7:0] tv_b    [5] = '{8'h83, 8'h05, 8'h01, 8'h01, 8'h00};
    logic       tv_s    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] tv_sum  [5] = '{8'h02, 8'hFE, 8'h80, 8'h80, 8'h00};
    logic [2:0] tv_c    [5] = '{3'b101, 3'b001, 3'b011, 3'b101, 3'b000};
    logic       tv_neg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] tv_disp [5] = '{8'h02, 8'h02, 8'h80, 8'h80, 8'h00};

    // Arithmetic reference in plain integers.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int   av, bv, t;
        logic ovf;
        exp_t e;
        av = int'(a[6:0]);
        if (a[7]) av = -av;
        bv = int'(b[6:0]);
        if (b[7]) bv = -bv;
        if (s) bv = -bv;
        t = av + bv;
        e.sum  = t[7:0];
        ovf    = (t > 127) || (t < -128);
        e.c[2] = ((av & 255) + (bv & 255)) > 255;
        e.c[1] = ovf;
        e.c[0] = (e.sum != 8'h00);
        if (e.sum[7] && !ovf) begin
            e.disp = 8'(-t);
            e.neg  = 1'b0;
        end else begin
            e.disp = e.sum;
            e.neg  = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [6:0] exp_segs(input logic [7:0] disp, input int d);
        logic [3:0] nib;
        nib = (d == 1) ? disp[7:4] : disp[3:0];
`ifdef SIGNMAG_SCAN_ZERO_BLANK_EN
        if (d == 1 && disp[7:4] == 4'h0) return 7'h7F;
`endif
        return ~hex_hi[nib];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_vec++; if (out_sum !== 8'h00) begin n_bad++; $display("FAIL reset_out_sum got %h exp 00", out_sum); end
        n_vec++; if (out_c !== 3'b000) begin n_bad++; $display("FAIL reset_out_c got %b exp 000", out_c); end
        n_vec++; if (neg !== 1'b1) begin n_bad++; $display("FAIL reset_neg got %b exp 1", neg); end
        n_vec++; if (AN !== 2'b10) begin n_bad++; $display("FAIL reset_AN got %b exp 10", AN); end
        n_vec++; if (SEGS !== 7'b1000000) begin n_bad++; $display("FAIL reset_SEGS got %b exp 1000000", SEGS); end
    endtask

    task automatic test_scan();
        logic [1:0] want;
        int         idx;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            idx  = ((k - 1) / 4) % 2;
            want = (idx == 0) ? 2'b10 : 2'b01;
            n_vec++; if (AN !== want) begin n_bad++; $display("FAIL scan_AN k=%0d got %b exp %b", k, AN, want); end
            n_vec++; if (SEGS !== exp_segs(8'h00, idx)) begin n_bad++; $display("FAIL scan_SEGS k=%0d got %b exp %b", k, SEGS, exp_segs(8'h00, idx)); end
        end
    endtask

    task automatic test_vectors();
        exp_t       e;
        logic [1:0] want;
        bit         found;
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = tv_a[v]; in_b = tv_b[v]; in_sub = tv_s[v];
            sb.push_back('{sum: tv_sum[v], c: tv_c[v], neg: tv_neg[v], disp: tv_disp[v]});
            @(negedge clk);
            in_valid = 1'b0;
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vec%0d_early_valid got %b exp 0", v, out_valid); end
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d_latency out_valid got %b exp 1", v, out_valid); end
            e = sb.pop_front();
            n_vec++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL vec%0d_sum got %h exp %h", v, out_sum, e.sum); end
            n_vec++; if (out_c !== e.c) begin n_bad++; $display("FAIL vec%0d_c got %b exp %b", v, out_c, e.c); end
            n_vec++; if (neg !== e.neg) begin n_bad++; $display("FAIL vec%0d_neg got %b exp %b", v, neg, e.neg); end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                want  = ~(2'b01 << d);
                found = 1'b0;
                for (int t = 0; t < 12; t++) begin
                    if (AN === want) begin found = 1'b1; break; end
                    @(negedge clk);
                end
                n_vec++;
                if (!found) begin
                    n_bad++; $display("FAIL vec%0d_digit%0d_timeout AN got %b exp %b", v, d, AN, want);
                end else if (SEGS !== exp_segs(e.disp, d)) begin
                    n_bad++; $display("FAIL vec%0d_digit%0d_SEGS got %b exp %b", v, d, SEGS, exp_segs(e.disp, d));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] ra, rb;
        logic       rs;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== (k >= 2 && k <= 4)) begin n_bad++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, out_valid, (k >= 2 && k <= 4)); end
            if (out_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL b2b_sum k=%0d got %h exp %h", k, out_sum, e.sum); end
                n_vec++; if (out_c !== e.c) begin n_bad++; $display("FAIL b2b_c k=%0d got %b exp %b", k, out_c, e.c); end
            end
            if (k < 3) begin
                ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
                in_valid = 1'b1; in_a = ra; in_b = rb; in_sub = rs;
                sb.push_back(model(ra, rb, rs));
            end else begin
                in_valid = 1'b0;
            end
        end
        n_vec++; if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_leftover got %0d exp 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_random();
        exp_t       e;
        logic [7:0] ra, rb;
        logic       rs;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL rand_unexpected_valid i=%0d got 1 exp 0", i);
                end else begin
                    e = sb.pop_front();
                    if (out_sum !== e.sum || out_c !== e.c || neg !== e.neg) begin
                        n_bad++;
                        $display("FAIL rand_result i=%0d got sum=%h c=%b neg=%b exp sum=%h c=%b neg=%b",
                                 i, out_sum, out_c, neg, e.sum, e.c, e.neg);
                    end
                end
            end
            if (i < 60 && $urandom_range(0, 3) != 0) begin
                ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
                in_valid = 1'b1; in_a = ra; in_b = rb; in_sub = rs;
                sb.push_back(model(ra, rb, rs));
            end else begin
                in_valid = 1'b0;
            end
        end
        n_vec++; if (sb.size() != 0) begin n_bad++; $display("FAIL rand_missing_results got %0d exp 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset_midpipe();
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_sub = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++; if (AN !== 2'b10) begin n_bad++; $display("FAIL midrst_AN got %b exp 10", AN); end
        n_vec++; if (SEGS !== 7'b1000000) begin n_bad++; $display("FAIL midrst_SEGS got %b exp 1000000", SEGS); end
        n_vec++; if (neg !== 1'b1) begin n_bad++; $display("FAIL midrst_neg got %b exp 1", neg); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_flushed k=%0d got %b exp 0", k, out_valid); end
        end
        n_vec++; if (out_sum !== 8'h00) begin n_bad++; $display("FAIL midrst_sum got %h exp 00", out_sum); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_vectors();
        test_back_to_back();
        test_random();
        test_reset_midpipe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
